// File: rtl/lsu_pkg.sv
// Shared encodings and lane helpers for the load/store unit bus master.
package lsu_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_WR_REQ,
      ST_WR_RESP,
      ST_DONE
   } lsu_state_e;

   // Byte-enable pattern for a store of the given size at byte offset off.
   function automatic logic [3:0] wstrb_gen(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] strb;
      case (size)
         SZ_B:    strb = 4'b0001 << off;
         SZ_H:    strb = 4'b0011 << off;
         default: strb = 4'b1111;
      endcase
      return strb;
   endfunction

   // Size 3 is reserved and is rejected the same way as a misaligned access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic mis;
      case (size)
         SZ_B:    mis = 1'b0;
         SZ_H:    mis = off[0];
         SZ_W:    mis = (off != 2'b00);
         default: mis = 1'b1;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_axi_master_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] st_data,
   output logic [31:0] st_wdata,
   output logic [3:0]  st_wstrb,
   input  logic [31:0] ld_raw,
   output logic [31:0] ld_data
);

   logic [31:0] ld_shift;

   assign st_wdata = st_data << {off, 3'b000};
   assign st_wstrb = wstrb_gen(size, off);
   assign ld_shift = ld_raw >> {off, 3'b000};

   // Pick the addressed lane and sign- or zero-extend it to 32 bits.
   always_comb begin
      ld_data = ld_shift;
      case (size)
         SZ_B:    ld_data = {{24{ld_shift[7] & ~is_unsigned}}, ld_shift[7:0]};
         SZ_H:    ld_data = {{16{ld_shift[15] & ~is_unsigned}}, ld_shift[15:0]};
         default: ld_data = ld_shift;
      endcase
   end

endmodule

// File: rtl/lsu_axi_master.sv
// Load/store unit master: one core request at a time onto a single-beat AXI-lite slave.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | ready for a request; misaligned requests go straight to DONE
// ST_RD_ADDR | arvalid held until arready
// ST_RD_DATA | rready high, waiting for rvalid
// ST_WR_REQ  | awvalid/wvalid each held until their own handshake
// ST_WR_RESP | both address and data accepted, waiting for bvalid
// ST_DONE    | one-cycle response pulse to the core
module lsu_axi_master
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wen,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] araddr,
   output logic              arvalid,
   input  logic              arready,
   input  logic [DATA_W-1:0] rdata,
   input  logic              rresp,
   input  logic              rvalid,
   output logic              rready,
   output logic [ADDR_W-1:0] awaddr,
   output logic              awvalid,
   input  logic              awready,
   output logic [DATA_W-1:0] wdata,
   output logic [3:0]        wstrb,
   output logic              wvalid,
   input  logic              wready,
   input  logic              bresp,
   input  logic              bvalid,
   output logic              bready
);

   lsu_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q, w_done_d;
   logic              b_done_q, b_done_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic [DATA_W-1:0] ld_data;
   logic              aw_now, w_now, b_now;

   lsu_lane_align u_align (
      .off         (addr_q[1:0]),
      .size        (size_q),
      .is_unsigned (uns_q),
      .st_data     (wdata_q),
      .st_wdata    (wdata),
      .st_wstrb    (wstrb),
      .ld_raw      (rdata),
      .ld_data     (ld_data)
   );

   assign req_ready  = (state_q == ST_IDLE);
   assign arvalid    = (state_q == ST_RD_ADDR);
   assign rready     = (state_q == ST_RD_DATA);
   assign awvalid    = (state_q == ST_WR_REQ) && !aw_done_q;
   assign wvalid     = (state_q == ST_WR_REQ) && !w_done_q;
   assign bready     = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP);
   assign araddr     = {addr_q[ADDR_W-1:2], 2'b00};
   assign awaddr     = {addr_q[ADDR_W-1:2], 2'b00};
   assign resp_valid = (state_q == ST_DONE);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   // Handshake progress this cycle, folding in what was already completed.
   assign aw_now = aw_done_q || awready;
   assign w_now  = w_done_q || wready;
   assign b_now  = b_done_q || bvalid;

   // Next-state and register updates for the request sequencer.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      size_d    = size_q;
      uns_d     = uns_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      b_done_d  = b_done_q;
      err_d     = err_q;
      rdata_d   = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d    = req_addr;
               wdata_d   = req_wdata;
               size_d    = req_size;
               uns_d     = req_unsigned;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               b_done_d  = 1'b0;
               err_d     = 1'b0;
               rdata_d   = '0;
               if (is_misaligned(req_size, req_addr[1:0])) begin
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end else if (req_wen) begin
                  state_d = ST_WR_REQ;
               end else begin
                  state_d = ST_RD_ADDR;
               end
            end
         end
         ST_RD_ADDR: begin
            if (arready) state_d = ST_RD_DATA;
         end
         ST_RD_DATA: begin
            if (rvalid) begin
               err_d   = rresp;
               rdata_d = rresp ? '0 : ld_data;
               state_d = ST_DONE;
            end
         end
         ST_WR_REQ: begin
            aw_done_d = aw_now;
            w_done_d  = w_now;
            if (bvalid && !b_done_q) begin
               b_done_d = 1'b1;
               err_d    = bresp;
            end
            // Stay here while either channel still owes a handshake so its valid stays up.
            if (aw_now && w_now && b_now) state_d = ST_DONE;
            else if (aw_now && w_now)     state_d = ST_WR_RESP;
         end
         ST_WR_RESP: begin
            if (bvalid) begin
               b_done_d = 1'b1;
               err_d    = bresp;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and request registers; reset drops any in-flight request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         size_q    <= '0;
         uns_q     <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         b_done_q  <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         size_q    <= size_d;
         uns_q     <= uns_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         b_done_q  <= b_done_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
Load/store unit bus master that converts one core memory request at a time into AXI-lite read or write transactions. It drives the single-beat AXI-lite slave (SRAM) directly.
Handles byte-lane steering on writes and lane extraction plus sign/zero extension on reads. Detects misaligned accesses locally and reports them as errors.

Parameters:
ADDR_W, 32, address width of request and AXI address channels
DATA_W, 32, data width; fixed at 32 (4 byte lanes)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  core request valid
req_ready  out  1  high only in IDLE
req_wen  in  1  1=store, 0=load
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, LSB-aligned
req_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as misaligned)
req_unsigned  in  1  zero-extend load when 1
resp_valid  out  1  one-cycle pulse on completion
resp_rdata  out  32  extended load data (0 for stores/errors)
resp_err  out  1  misaligned, or bus rresp/bresp nonzero
araddr, arvalid / arready  out,out / in  32,1 / 1  AR channel
rdata, rresp, rvalid / rready  in,in,in / out  32,1,1 / 1  R channel
awaddr, awvalid / awready  out,out / in  32,1 / 1  AW channel
wdata, wstrb, wvalid / wready  out,out,out / in  32,4,1 / 1  W channel
bresp, bvalid / bready  in,in / out  1,1 / 1  B channel

Behaviour:
- Reset (async, rst_n=0): state IDLE. arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err = 0; resp_rdata = 0. Address/data registers = 0. Applies immediately mid-transaction; the in-flight request is dropped.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE: req_ready=1. On req_valid, latch the request.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size=3): go to DONE with err=1; no bus activity.
  - Otherwise load goes to RD_ADDR, store goes to WR_REQ.
- Bus address is always word-aligned: {addr[31:2], 2'b00}; off = addr[1:0].
- RD_ADDR: arvalid=1 and held until arready. araddr stable. On handshake go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata and rresp, go to DONE.
  - Extract lane: byte = rdata[8*off+:8], half = rdata[8*off+:16].
  - Sign-extend unless req_unsigned.
- WR_REQ: awvalid and wvalid both asserted on entry. Each drops independently after its own handshake, tracked by aw_done/w_done flags.
  - wstrb: byte = 4'b0001<<off, half = 4'b0011<<off, word = 4'b1111.
  - wdata = req_wdata shifted left by 8*off.
  - bready=1 in WR_REQ and WR_RESP.
  - bvalid is captured whenever it arrives (slave pulses it for one cycle). Once aw_done, w_done and b_done are all set, go to DONE; otherwise go to WR_RESP.
- WR_RESP: wait for bvalid, then go to DONE.
- DONE: resp_valid=1 for exactly one cycle with resp_rdata/resp_err. Return to IDLE next cycle.
- Latency with a zero-wait slave:
  - Load: accept at edge E0, AR handshake E1, R handshake E2, resp_valid high during the cycle after E2.
  - Store: aw/w handshake E1, bvalid captured E2, resp_valid after E2.
  - Misaligned: resp_valid the cycle after accept.
- Requests arriving while busy are ignored (req_ready=0). Back-to-back throughput is one request per completion plus one cycle.
- Valid signals never drop before their handshake. Payloads remain stable while valid is high.

Decomposition:
- Package lsu_pkg: size encodings (SZ_B/SZ_H/SZ_W), state enum, function for wstrb generation.
- One sub-module, lsu_lane_align: combinational store shift/strobe and load extract/extend, keyed by off, size, unsigned.

Test Plan:
- Load word addr 0x80000004, slave returns 0xDEADBEEF, rresp=0 -> araddr=0x80000004, resp_rdata=0xDEADBEEF, err=0, resp_valid 3 cycles after accept.
- Load byte signed addr 0x80000003, rdata 0x80AA5511 -> resp_rdata=0xFFFFFF80; same with unsigned -> 0x00000080.
- Store half 0x1234 to addr 0x80000002 -> awaddr=0x80000000, wdata=0x12340000, wstrb=4'b1100, resp_valid after bvalid, err=0.
- Store word with awready delayed 3 cycles, wready=1 -> wvalid drops after 1 cycle, awvalid held 3 cycles, single resp_valid pulse.
- Word load at 0x80000001 -> no arvalid ever, resp_valid next cycle with err=1, rdata=0.
- rst_n asserted while in RD_DATA -> all valids 0 immediately. Next request after reset completes normally.
